// File: rtl/vmicro16_timer_multi_apb_pkg.sv
// rtl/vmicro16_timer_multi_apb_pkg.sv - shared register map and CTRL bit layout for the multi-channel timer
// Contents:
//   TIMR_REG_*   per-channel register offsets (S_PADDR[1:0])
//   TIMR_CTRL_*  bit positions inside the CTRL register
package vmicro16_timer_multi_apb_pkg;

    localparam logic [1:0] TIMR_REG_LOAD = 2'd0;
    localparam logic [1:0] TIMR_REG_CTRL = 2'd1;
    localparam logic [1:0] TIMR_REG_PRES = 2'd2;
    localparam logic [1:0] TIMR_REG_STAT = 2'd3;

    localparam int TIMR_CTRL_EN       = 0;
    localparam int TIMR_CTRL_PERIODIC = 1;
    localparam int TIMR_CTRL_IE       = 2;
    localparam int TIMR_CTRL_WIDTH    = 3;

endpackage

// File: rtl/vmicro16_timer_chan.sv
// rtl/vmicro16_timer_chan.sv - one prescaled down-counter channel with its register file
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   wr_en_i          APB write to this channel in the access phase
//   reg_i            register offset (LOAD/CTRL/PRES/STAT)
//   wdata_i          APB write data
//   rdata_o          read value of the register selected by reg_i
//   pending_o, ie_o  expiry pending flag and interrupt enable, for the irq reduction
//   out_o            registered one-cycle expiry pulse
module vmicro16_timer_chan
    import vmicro16_timer_multi_apb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PRES_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [1:0]            reg_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  pending_o,
    output logic                  ie_o,
    output logic                  out_o
);

    logic [DATA_WIDTH-1:0]      load_q, load_d;
    logic [DATA_WIDTH-1:0]      cnt_q, cnt_d;
    logic [TIMR_CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [PRES_WIDTH-1:0]      pres_q, pres_d;
    logic [PRES_WIDTH-1:0]      pres_cnt_q, pres_cnt_d;
    logic                       pending_q, pending_d;
    logic                       out_q, out_d;

    logic wr_load, wr_ctrl, wr_pres, wr_stat;
    logic en, tick, expire;

    always_comb begin
        wr_load = wr_en_i && (reg_i == TIMR_REG_LOAD);
        wr_ctrl = wr_en_i && (reg_i == TIMR_REG_CTRL);
        wr_pres = wr_en_i && (reg_i == TIMR_REG_PRES);
        wr_stat = wr_en_i && (reg_i == TIMR_REG_STAT);

        en     = ctrl_q[TIMR_CTRL_EN];
        tick   = en && (pres_cnt_q == '0);
        expire = tick && (cnt_q == '0);

        load_d     = load_q;
        cnt_d      = cnt_q;
        ctrl_d     = ctrl_q;
        pres_d     = pres_q;
        pres_cnt_d = pres_q;

        // Prescaler free-runs only while enabled; when stopped it sits at
        // PRES so the first tick after enabling lands PRES+1 edges later.
        if (en) begin
            pres_cnt_d = tick ? pres_q : (pres_cnt_q - 1'b1);
        end

        if (tick) begin
            if (expire) begin
                if (ctrl_q[TIMR_CTRL_PERIODIC]) begin
                    cnt_d = load_q;
                end else begin
                    ctrl_d[TIMR_CTRL_EN] = 1'b0;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        out_d = expire;
        // A new expiry in the same cycle as a clear keeps the flag set.
        pending_d = expire || (pending_q && !(wr_stat && wdata_i[0]));

        // Bus writes are applied last so they override the timer's own update.
        if (wr_load) begin
            load_d = wdata_i;
            cnt_d  = wdata_i;
        end
        if (wr_ctrl) begin
            ctrl_d = wdata_i[TIMR_CTRL_WIDTH-1:0];
        end
        if (wr_pres) begin
            pres_d     = wdata_i[PRES_WIDTH-1:0];
            pres_cnt_d = wdata_i[PRES_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q     <= '0;
            cnt_q      <= '0;
            ctrl_q     <= '0;
            pres_q     <= '0;
            pres_cnt_q <= '0;
            pending_q  <= 1'b0;
            out_q      <= 1'b0;
        end else begin
            load_q     <= load_d;
            cnt_q      <= cnt_d;
            ctrl_q     <= ctrl_d;
            pres_q     <= pres_d;
            pres_cnt_q <= pres_cnt_d;
            pending_q  <= pending_d;
            out_q      <= out_d;
        end
    end

    // LOAD reads back the live counter, not the reload value.
    always_comb begin
        rdata_o = '0;
        case (reg_i)
            TIMR_REG_LOAD: rdata_o = cnt_q;
            TIMR_REG_CTRL: rdata_o[TIMR_CTRL_WIDTH-1:0] = ctrl_q;
            TIMR_REG_PRES: rdata_o[PRES_WIDTH-1:0] = pres_q;
            default:       rdata_o[0] = pending_q;
        endcase
    end

    assign pending_o = pending_q;
    assign ie_o      = ctrl_q[TIMR_CTRL_IE];
    assign out_o     = out_q;

endmodule

// File: rtl/vmicro16_timer_multi_apb.sv
// rtl/vmicro16_timer_multi_apb.sv - multi-channel APB timer: address decode, read mux and irq reduction
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   S_PADDR          {channel, register offset}
//   S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA   APB request
//   S_PRDATA, S_PREADY                       APB response, zero wait states
//   out              per-channel one-cycle expiry pulses
//   irq              OR over channels of pending & IE
module vmicro16_timer_multi_apb
    import vmicro16_timer_multi_apb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 4,
    parameter int PRES_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(CHANNELS)+1:0]  S_PADDR,
    input  logic                         S_PWRITE,
    input  logic                         S_PSELx,
    input  logic                         S_PENABLE,
    input  logic [DATA_WIDTH-1:0]        S_PWDATA,
    output logic [DATA_WIDTH-1:0]        S_PRDATA,
    output logic                         S_PREADY,
    output logic [CHANNELS-1:0]          out,
    output logic                         irq
);

    localparam int CH_W = $clog2(CHANNELS);

    logic                  access;
    logic [CH_W-1:0]       chan_sel;
    logic [1:0]            reg_sel;
    logic [DATA_WIDTH-1:0] chan_rdata [CHANNELS];
    logic [CHANNELS-1:0]   pending;
    logic [CHANNELS-1:0]   ie;

    assign access   = S_PSELx && S_PENABLE;
    assign chan_sel = S_PADDR[CH_W+1:2];
    assign reg_sel  = S_PADDR[1:0];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        vmicro16_timer_chan #(
            .DATA_WIDTH (DATA_WIDTH),
            .PRES_WIDTH (PRES_WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst_n     (reset),
            .wr_en_i   (access && S_PWRITE && (chan_sel == CH_W'(g))),
            .reg_i     (reg_sel),
            .wdata_i   (S_PWDATA),
            .rdata_o   (chan_rdata[g]),
            .pending_o (pending[g]),
            .ie_o      (ie[g]),
            .out_o     (out[g])
        );
    end

    // CHANNELS is a power of two, so every chan_sel value maps to a channel.
    assign S_PRDATA = access ? chan_rdata[chan_sel] : '0;
    assign S_PREADY = access;
    assign irq      = |(pending & ie);

endmodule

// File: tb/tb_vmicro16_timer_multi_apb.sv
// tb/tb_vmicro16_timer_multi_apb.sv - self-checking bench for vmicro16_timer_multi_apb
module tb_vmicro16_timer_multi_apb;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  paddr = '0;
    logic        pwrite = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [15:0] pwdata = '0;
    logic [15:0] prdata;
    logic        pready;
    logic [3:0]  tout;
    logic        irq;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    vmicro16_timer_multi_apb #(
        .DATA_WIDTH (16),
        .CHANNELS   (4),
        .PRES_WIDTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .S_PADDR   (paddr),
        .S_PWRITE  (pwrite),
        .S_PSELx   (psel),
        .S_PENABLE (penable),
        .S_PWDATA  (pwdata),
        .S_PRDATA  (prdata),
        .S_PREADY  (pready),
        .out       (tout),
        .irq       (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input int ch, input int rg, input int data, output int edge_o);
        @(negedge clk);
        paddr   = {ch[1:0], rg[1:0]};
        pwrite  = 1'b1;
        pwdata  = data[15:0];
        psel    = 1'b1;
        penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(posedge clk);
        #1;
        edge_o  = cyc;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_read(input int ch, input int rg, output logic [15:0] data);
        @(negedge clk);
        paddr   = {ch[1:0], rg[1:0]};
        pwrite  = 1'b0;
        psel    = 1'b1;
        penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        data = prdata;
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    // Leaves a read access phase open so S_PRDATA follows the register every cycle.
    task automatic watch_begin(input int ch, input int rg);
        @(negedge clk);
        paddr   = {ch[1:0], rg[1:0]};
        pwrite  = 1'b0;
        psel    = 1'b1;
        penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
    endtask

    task automatic watch_end();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    // Reference model. Ticks fall on edges w+j*(p+1), j>=1 (w = enable edge).
    // The counter holds n after reference edge x; ticks after x count it down
    // and past zero it reloads to l (periodic) or stays at zero (one-shot).
    function automatic int ticks_between(int x, int e, int w, int p);
        return (e - w) / (p + 1) - (x - w) / (p + 1);
    endfunction

    function automatic int m_cnt(int e, int w, int x, int n, int l, int p, bit per);
        int k;
        k = ticks_between(x, e, w, p);
        if (k <= n) return n - k;
        if (!per) return 0;
        return l - ((k - n - 1) % (l + 1));
    endfunction

    // True when edge c is an expiry edge, i.e. out is high in the cycle after c.
    function automatic bit m_out(int c, int w, int x, int n, int l, int p, bit per);
        int k;
        if (c <= x) return 1'b0;
        if (((c - w) % (p + 1)) != 0) return 1'b0;
        k = ticks_between(x, c, w, p);
        if (k < n + 1) return 1'b0;
        if (!per) return (k == n + 1);
        return ((k - n - 1) % (l + 1)) == 0;
    endfunction

    initial begin
        int w, x, s, d, c;
        int ch, l, p;
        bit per, exp_pend;
        logic [15:0] rd;

        // ---------------- reset with bus activity ----------------
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            paddr   = 4'($urandom_range(0, 15));
            pwrite  = 1'($urandom_range(0, 1));
            pwdata  = 16'($urandom);
            psel    = 1'b1;
            penable = 1'b1;
            #1;
            if (!pwrite) chk("reset_prdata", 32'(prdata), 0);
            chk("reset_out", 32'(tout), 0);
            chk("reset_irq", 32'(irq), 0);
        end
        watch_end();
        pwrite = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int chn = 0; chn < 4; chn++) begin
            for (int r = 0; r < 4; r++) begin
                apb_read(chn, r, rd);
                chk($sformatf("reset_reg_ch%0d_r%0d", chn, r), 32'(rd), 0);
            end
        end

        // ---------------- read without PENABLE returns 0 ----------------
        apb_write(0, 0, 16'h1234, w);
        @(negedge clk);
        paddr = 4'h0; psel = 1'b1; penable = 1'b0;
        #1;
        chk("noen_prdata", 32'(prdata), 0);
        chk("noen_pready", 32'(pready), 0);
        @(negedge clk);
        penable = 1'b1;
        #1;
        chk("en_prdata", 32'(prdata), 32'h1234);
        chk("en_pready", 32'(pready), 1);
        watch_end();

        // ---------------- ch0 periodic, LOAD=3, PRES=0 ----------------
        apb_write(0, 0, 3, x);
        apb_write(0, 2, 0, x);
        apb_write(0, 1, 3, w);
        watch_begin(0, 0);
        for (int i = 0; i < 16; i++) begin
            #1;
            c = cyc;
            chk($sformatf("ch0_cnt@%0d", c - w), 32'(prdata), 32'(m_cnt(c, w, w, 3, 3, 0, 1'b1)));
            chk($sformatf("ch0_out@%0d", c - w), 32'(tout),
                32'(m_out(c, w, w, 3, 3, 0, 1'b1)) & 32'h1);
            chk("ch0_irq", 32'(irq), 0);
            @(negedge clk);
        end
        watch_end();
        apb_write(0, 1, 0, d);
        apb_write(0, 3, 1, d);

        // ---------------- ch2 one-shot, LOAD=2, PRES=4, IE ----------------
        apb_write(2, 0, 2, x);
        apb_write(2, 2, 4, x);
        apb_write(2, 1, 5, w);
        watch_begin(2, 1);
        for (int i = 0; i < 24; i++) begin
            #1;
            c = cyc;
            chk($sformatf("ch2_ctrl@%0d", c - w), 32'(prdata), (c >= w + 15) ? 4 : 5);
            chk($sformatf("ch2_out@%0d", c - w), 32'(tout), (c == w + 15) ? 32'h4 : 0);
            chk($sformatf("ch2_irq@%0d", c - w), 32'(irq), (c >= w + 15) ? 1 : 0);
            @(negedge clk);
        end
        watch_end();
        apb_read(2, 0, rd);
        chk("ch2_cnt_after", 32'(rd), 0);
        chk("ch2_irq_before_clr", 32'(irq), 1);
        apb_write(2, 3, 1, s);
        chk("ch2_irq_after_clr", 32'(irq), 0);
        apb_read(2, 3, rd);
        chk("ch2_stat_after_clr", 32'(rd), 0);
        apb_write(2, 1, 0, d);

        // ---------------- ch1 periodic every cycle, clear vs expiry ----------------
        apb_write(1, 0, 0, x);
        apb_write(1, 2, 0, x);
        apb_write(1, 1, 7, w);
        repeat (3) @(negedge clk);
        apb_write(1, 3, 1, s);
        chk("ch1_irq_after_clr", 32'(irq), 1);
        apb_read(1, 3, rd);
        chk("ch1_stat_set_wins", 32'(rd), 1);
        apb_write(1, 1, 0, d);
        apb_write(1, 3, 1, d);
        apb_read(1, 3, rd);
        chk("ch1_stat_cleared", 32'(rd), 0);
        chk("ch1_irq_cleared", 32'(irq), 0);

        // ---------------- randomized single-channel runs ----------------
        for (int t = 0; t < 6; t++) begin
            ch  = $urandom_range(0, 3);
            l   = $urandom_range(0, 6);
            p   = $urandom_range(0, 3);
            per = 1'($urandom_range(0, 1));
            apb_write(ch, 1, 0, x);
            apb_write(ch, 2, p, x);
            apb_write(ch, 0, l, x);
            apb_write(ch, 3, 1, x);
            apb_write(ch, 1, per ? 3 : 1, w);
            watch_begin(ch, 0);
            for (int i = 0; i < 30; i++) begin
                #1;
                c = cyc;
                chk($sformatf("rnd%0d_ch%0d_cnt@%0d", t, ch, c - w), 32'(prdata),
                    32'(m_cnt(c, w, w, l, l, p, per)));
                chk($sformatf("rnd%0d_ch%0d_out@%0d", t, ch, c - w), 32'(tout),
                    m_out(c, w, w, l, l, p, per) ? (32'h1 << ch) : 0);
                @(negedge clk);
            end
            watch_end();
            apb_write(ch, 1, 0, d);
            exp_pend = 1'b0;
            for (int e = w + 1; e <= d; e++) exp_pend |= m_out(e, w, w, l, l, p, per);
            apb_read(ch, 3, rd);
            chk($sformatf("rnd%0d_ch%0d_pending", t, ch), 32'(rd), 32'(exp_pend));
            apb_write(ch, 3, 1, x);
        end

        // ---------------- ch3 LOAD rewrite mid-count, then async reset ----------------
        apb_write(3, 0, 100, x);
        apb_write(3, 2, 9, x);
        apb_write(3, 1, 3, w);
        watch_begin(3, 0);
        for (int i = 0; i < 25; i++) begin
            #1;
            c = cyc;
            chk($sformatf("ch3_cnt@%0d", c - w), 32'(prdata), 32'(m_cnt(c, w, w, 100, 100, 9, 1'b1)));
            @(negedge clk);
        end
        watch_end();
        apb_write(3, 0, 5, x);
        watch_begin(3, 0);
        for (int i = 0; i < 70; i++) begin
            #1;
            c = cyc;
            chk($sformatf("ch3_reload_cnt@%0d", c - w), 32'(prdata), 32'(m_cnt(c, w, x, 5, 5, 9, 1'b1)));
            chk($sformatf("ch3_reload_out@%0d", c - w), 32'(tout),
                m_out(c, w, x, 5, 5, 9, 1'b1) ? 32'h8 : 0);
            @(negedge clk);
        end
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_prdata", 32'(prdata), 0);
        chk("async_rst_out", 32'(tout), 0);
        chk("async_rst_irq", 32'(irq), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            #1;
            chk("post_rst_cnt", 32'(prdata), 0);
            chk("post_rst_out", 32'(tout), 0);
            @(negedge clk);
        end
        watch_end();
        apb_read(3, 1, rd);
        chk("post_rst_ctrl", 32'(rd), 0);
        apb_read(3, 2, rd);
        chk("post_rst_pres", 32'(rd), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
